// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if
//   Bundles the load/count controls and status outputs of one
//   down_counter_timer stage. The clock and reset are not carried here.
//   Signals:
//     parIn      load value, also copied into the reload register
//     ld         synchronous load
//     cen, bi    count enable and borrow-in; both must be high to decrement
//     autoReload 1 = reload on underflow, 0 = one-shot
//     parOut     current count
//     bo         borrow-out, high while the count is zero
//     tc         one-cycle terminal-count pulse
//     busy       high while counting
//     done       high once a one-shot run has expired
//   Modports: master drives the controls, slave is the counter itself.
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] parIn;
  logic             ld;
  logic             cen;
  logic             bi;
  logic             autoReload;
  logic [WIDTH-1:0] parOut;
  logic             bo;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output parIn, ld, cen, bi, autoReload,
    input  parOut, bo, tc, busy, done
  );

  modport slave (
    input  parIn, ld, cen, bi, autoReload,
    output parOut, bo, tc, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Loadable down counter with a reload register, a cascadable borrow chain
//   and a registered terminal-count pulse. A three-state FSM (IDLE, RUN,
//   EXPIRED) gives one-shot and auto-reload timer behaviour.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  down_counter_timer_if.slave (controls in, count/status out)
//   Stages cascade by wiring a lower stage's bo into the next stage's bi.
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             dec_s;
  logic             zero_s;

  assign dec_s  = bus.cen & bus.bi;
  assign zero_s = (cnt_q == ZERO);

  // Next-state logic: load beats counting; only RUN decrements.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (bus.ld) begin
      cnt_d   = bus.parIn;
      rld_d   = bus.parIn;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dec_s) begin
            if (!zero_s) begin
              cnt_d = cnt_q - ONE;
            end else begin
              // Underflow: never wrap; either reload or park at zero.
              tc_d = 1'b1;
              if (bus.autoReload) begin
                cnt_d = rld_q;
              end else begin
                state_d = ST_EXPIRED;
              end
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          // Unused encoding: fall back to a safe, non-counting state.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, count, reload and terminal-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= ZERO;
      rld_q   <= ZERO;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  // bo must be combinational so a cascaded stage sees the borrow in the same cycle.
  assign bus.parOut = cnt_q;
  assign bus.bo     = zero_s;
  assign bus.tc     = tc_q;
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  down_counter_timer_if #(.WIDTH(8)) dut_if ();
  down_counter_timer_if #(.WIDTH(8)) lo_if ();
  down_counter_timer_if #(.WIDTH(8)) hi_if ();

  down_counter_timer #(.WIDTH(8)) u_dut (.clk(clk), .rst(rst), .bus(dut_if));
  down_counter_timer #(.WIDTH(8)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if));
  down_counter_timer #(.WIDTH(8)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if));

  assign hi_if.bi = lo_if.bo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (dut_if.parOut !== 8'h00) begin errors++; $display("FAIL reset_parOut got=%0h exp=00", dut_if.parOut); end
    checks++; if (dut_if.bo !== 1'b1) begin errors++; $display("FAIL reset_bo got=%0b exp=1", dut_if.bo); end
    checks++; if ({dut_if.busy, dut_if.done, dut_if.tc} !== 3'b000) begin errors++; $display("FAIL reset_status got=%03b exp=000", {dut_if.busy, dut_if.done, dut_if.tc}); end
    tick();
    rst = 1'b1;
    dut_if.ld = 1'b1; dut_if.parIn = 8'h37; dut_if.cen = 1'b0; dut_if.bi = 1'b1;
    tick();
    dut_if.ld = 1'b0;
    checks++; if (dut_if.parOut !== 8'h37 || dut_if.busy !== 1'b1) begin errors++; $display("FAIL load37 got=%0h busy=%0b exp=37 busy=1", dut_if.parOut, dut_if.busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dut_if.parOut !== 8'h00 || dut_if.bo !== 1'b1) begin errors++; $display("FAIL midreset_count got=%0h bo=%0b exp=00 bo=1", dut_if.parOut, dut_if.bo); end
    checks++; if ({dut_if.busy, dut_if.done, dut_if.tc} !== 3'b000) begin errors++; $display("FAIL midreset_status got=%03b exp=000", {dut_if.busy, dut_if.done, dut_if.tc}); end
    dut_if.cen = 1'b1; dut_if.bi = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dut_if.parOut !== 8'h00 || dut_if.busy !== 1'b0) begin errors++; $display("FAIL idle_nocount got=%0h busy=%0b exp=00 busy=0", dut_if.parOut, dut_if.busy); end
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h03, 8'h02, 8'h01, 8'h00};
    dut_if.ld = 1'b1; dut_if.parIn = 8'h03; dut_if.autoReload = 1'b0;
    dut_if.cen = 1'b1; dut_if.bi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      dut_if.ld = 1'b0;
      checks++; if (dut_if.parOut !== exp_seq[i] || dut_if.tc !== 1'b0 || dut_if.busy !== 1'b1) begin errors++; $display("FAIL oneshot_step%0d got=%0h tc=%0b busy=%0b exp=%0h tc=0 busy=1", i, dut_if.parOut, dut_if.tc, dut_if.busy, exp_seq[i]); end
    end
    tick();
    checks++; if ({dut_if.tc, dut_if.done, dut_if.busy} !== 3'b110 || dut_if.parOut !== 8'h00) begin errors++; $display("FAIL oneshot_expire got tc/done/busy=%03b cnt=%0h exp=110 cnt=00", {dut_if.tc, dut_if.done, dut_if.busy}, dut_if.parOut); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (dut_if.parOut !== 8'h00 || dut_if.tc !== 1'b0 || dut_if.done !== 1'b1) begin errors++; $display("FAIL oneshot_hold got=%0h tc=%0b done=%0b exp=00 tc=0 done=1", dut_if.parOut, dut_if.tc, dut_if.done); end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_cnt [6];
    logic       exp_tc  [6];
    exp_cnt = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
    exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dut_if.ld = 1'b1; dut_if.parIn = 8'h02; dut_if.autoReload = 1'b1;
    tick();
    dut_if.ld = 1'b0;
    checks++; if (dut_if.parOut !== 8'h02 || dut_if.tc !== 1'b0) begin errors++; $display("FAIL auto_load got=%0h tc=%0b exp=02 tc=0", dut_if.parOut, dut_if.tc); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (dut_if.parOut !== exp_cnt[i] || dut_if.tc !== exp_tc[i] || dut_if.busy !== 1'b1) begin errors++; $display("FAIL auto_step%0d got=%0h tc=%0b busy=%0b exp=%0h tc=%0b busy=1", i, dut_if.parOut, dut_if.tc, dut_if.busy, exp_cnt[i], exp_tc[i]); end
    end
  endtask

  task automatic test_gating_priority();
    dut_if.ld = 1'b1; dut_if.parIn = 8'h05; dut_if.autoReload = 1'b0;
    tick();
    dut_if.ld = 1'b0; dut_if.cen = 1'b1; dut_if.bi = 1'b0;
    tick(); tick();
    checks++; if (dut_if.parOut !== 8'h05) begin errors++; $display("FAIL gate_bi got=%0h exp=05", dut_if.parOut); end
    dut_if.cen = 1'b0; dut_if.bi = 1'b1;
    tick();
    checks++; if (dut_if.parOut !== 8'h05) begin errors++; $display("FAIL gate_cen got=%0h exp=05", dut_if.parOut); end
    dut_if.cen = 1'b1; dut_if.ld = 1'b1; dut_if.parIn = 8'hA0;
    tick();
    dut_if.ld = 1'b0;
    checks++; if (dut_if.parOut !== 8'hA0) begin errors++; $display("FAIL ld_over_dec got=%0h exp=a0", dut_if.parOut); end
    tick();
    checks++; if (dut_if.parOut !== 8'h9F) begin errors++; $display("FAIL dec_after_ld got=%0h exp=9f", dut_if.parOut); end
    dut_if.ld = 1'b1; dut_if.parIn = 8'h00;
    tick();
    dut_if.ld = 1'b0;
    tick();
    checks++; if (dut_if.done !== 1'b1 || dut_if.tc !== 1'b1) begin errors++; $display("FAIL ld0_oneshot done=%0b tc=%0b exp done=1 tc=1", dut_if.done, dut_if.tc); end
    dut_if.ld = 1'b1; dut_if.parIn = 8'h07;
    tick();
    dut_if.ld = 1'b0;
    checks++; if (dut_if.parOut !== 8'h07 || {dut_if.busy, dut_if.done, dut_if.tc} !== 3'b100) begin errors++; $display("FAIL ld_in_expired got=%0h status=%03b exp=07 status=100", dut_if.parOut, {dut_if.busy, dut_if.done, dut_if.tc}); end
  endtask

  task automatic test_edge_values();
    int         tc_edge;
    logic [7:0] exp_cnt;
    dut_if.ld = 1'b1; dut_if.parIn = 8'h00; dut_if.autoReload = 1'b1;
    dut_if.cen = 1'b1; dut_if.bi = 1'b1;
    tick();
    dut_if.ld = 1'b0;
    checks++; if (dut_if.tc !== 1'b0 || dut_if.parOut !== 8'h00) begin errors++; $display("FAIL zero_load tc=%0b cnt=%0h exp tc=0 cnt=00", dut_if.tc, dut_if.parOut); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (dut_if.tc !== 1'b1 || dut_if.parOut !== 8'h00 || dut_if.busy !== 1'b1) begin errors++; $display("FAIL zero_auto%0d tc=%0b cnt=%0h busy=%0b exp tc=1 cnt=00 busy=1", i, dut_if.tc, dut_if.parOut, dut_if.busy); end
    end
    dut_if.cen = 1'b0;
    tick();
    checks++; if (dut_if.tc !== 1'b0) begin errors++; $display("FAIL zero_auto_stop tc=%0b exp=0", dut_if.tc); end
    dut_if.ld = 1'b1; dut_if.parIn = 8'hFF; dut_if.autoReload = 1'b0; dut_if.cen = 1'b1;
    tick();
    dut_if.ld = 1'b0;
    tc_edge = 0;
    exp_cnt = 8'hFF;
    for (int n = 1; n <= 300 && tc_edge == 0; n++) begin
      tick();
      if (n <= 255) exp_cnt = exp_cnt - 8'h01;
      if (dut_if.tc === 1'b1) tc_edge = n;
      checks++; if (dut_if.parOut !== exp_cnt) begin errors++; $display("FAIL ff_count edge=%0d got=%0h exp=%0h", n, dut_if.parOut, exp_cnt); end
    end
    checks++; if (tc_edge != 256) begin errors++; $display("FAIL ff_tc_edge got=%0d exp=256", tc_edge); end
    checks++; if (dut_if.done !== 1'b1) begin errors++; $display("FAIL ff_done got=%0b exp=1", dut_if.done); end
  endtask

  task automatic test_cascade();
    logic [15:0] exp_val [4];
    exp_val = '{16'h0101, 16'h0100, 16'h0001, 16'h0000};
    lo_if.ld = 1'b1; hi_if.ld = 1'b1;
    lo_if.parIn = 8'h01; hi_if.parIn = 8'h01;
    lo_if.autoReload = 1'b1; hi_if.autoReload = 1'b0;
    lo_if.cen = 1'b1; hi_if.cen = 1'b1; lo_if.bi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      lo_if.ld = 1'b0; hi_if.ld = 1'b0;
      checks++; if ({hi_if.parOut, lo_if.parOut} !== exp_val[i] || hi_if.tc !== 1'b0) begin errors++; $display("FAIL cascade_step%0d got=%0h hi_tc=%0b exp=%0h hi_tc=0", i, {hi_if.parOut, lo_if.parOut}, hi_if.tc, exp_val[i]); end
      if (i == 2) begin
        checks++; if (lo_if.tc !== 1'b1) begin errors++; $display("FAIL cascade_lo_borrow tc=%0b exp=1", lo_if.tc); end
      end
    end
    tick();
    checks++; if (hi_if.tc !== 1'b1 || hi_if.done !== 1'b1 || lo_if.tc !== 1'b1) begin errors++; $display("FAIL cascade_hi_tc hi_tc=%0b hi_done=%0b lo_tc=%0b exp 1 1 1", hi_if.tc, hi_if.done, lo_if.tc); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    dut_if.parIn = 8'h00; dut_if.ld = 1'b0; dut_if.cen = 1'b0; dut_if.bi = 1'b0; dut_if.autoReload = 1'b0;
    lo_if.parIn = 8'h00; lo_if.ld = 1'b0; lo_if.cen = 1'b0; lo_if.bi = 1'b0; lo_if.autoReload = 1'b0;
    hi_if.parIn = 8'h00; hi_if.ld = 1'b0; hi_if.cen = 1'b0; hi_if.autoReload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_gating_priority();
    test_edge_values();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
